// File: rtl/fetch_pkg.sv
// Shared types, defaults and helpers for the instruction fetch stage.
package fetch_pkg;

    // Fetch control states: normal issue, or holding a response in the skid entry.
    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_STALL = 1'b1
    } fetch_state_e;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
    localparam int          FETCH_ADDR_W   = 18;
    localparam int          FETCH_DATA_W   = 32;

    // Byte address to BRAM word index; the caller truncates to its address width.
    function automatic logic [29:0] pc_to_word(input logic [31:0] pc);
        return 30'(pc >> 2);
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: BRAM read port, branch redirect and decode handshake.
// master = fetch unit side, slave = BRAM / execute / decode side.
interface fetch_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int DATA_W = FETCH_DATA_W
);
    logic              mem_enable;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              branch_valid;
    logic [31:0]       branch_target;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst_data;
    logic [31:0]       inst_pc;

    modport master (
        output mem_enable, mem_address, inst_valid, inst_data, inst_pc,
        input  mem_data, branch_valid, branch_target, inst_ready
    );

    modport slave (
        input  mem_enable, mem_address, inst_valid, inst_data, inst_pc,
        output mem_data, branch_valid, branch_target, inst_ready
    );
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {instruction, pc} holding buffer used when a BRAM response
// arrives while decode is back-pressuring the output register.
module fetch_skid_buf #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              unload_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [31:0]       pc_i,
    output logic              full_o,
    output logic [DATA_W-1:0] data_o,
    output logic [31:0]       pc_o
);
    logic              full_q;
    logic [DATA_W-1:0] data_q;
    logic [31:0]       pc_q;

    // Entry storage: flush wins over load, load wins over unload.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            full_q <= 1'b0;
            data_q <= '0;
            pc_q   <= 32'd0;
        end else if (load_i) begin
            full_q <= 1'b1;
            data_q <= data_i;
            pc_q   <= pc_i;
        end else if (unload_i) begin
            full_q <= 1'b0;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;
    assign pc_o   = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the BRAM read port, absorbs the
// one-cycle BRAM latency and hands instructions to decode over valid/ready.
// Optional build macro FETCH_PERF_EN adds saturating accept/stall counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
    parameter int          ADDR_W   = FETCH_ADDR_W,
    parameter int          DATA_W   = FETCH_DATA_W
) (
    input  logic      clk,
    input  logic      reset,
    fetch_if.master   bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);
    fetch_state_e      state_q;
    logic [31:0]       pc_q;
    logic [31:0]       pc_d;
    logic              pend_q;
    logic [31:0]       pend_pc_q;
    logic              inst_valid_q;
    logic [DATA_W-1:0] inst_data_q;
    logic [31:0]       inst_pc_q;

    logic              out_free_s;
    logic              issue_s;
    logic              capture_s;
    logic              skid_load_s;
    logic              skid_unload_s;
    logic              skid_full_s;
    logic [DATA_W-1:0] skid_data_s;
    logic [31:0]       skid_pc_s;

    assign pc_d = pc_q + 32'd4;

    // Issue / capture decisions; a branch in the same cycle suppresses all of them.
    always_comb begin
        out_free_s    = !inst_valid_q || bus.inst_ready;
        issue_s       = !reset && !bus.branch_valid && (state_q == S_RUN) && out_free_s;
        capture_s     = !reset && !bus.branch_valid && (state_q == S_RUN) && pend_q;
        skid_load_s   = capture_s && !out_free_s;
        skid_unload_s = !reset && !bus.branch_valid && (state_q == S_STALL)
                        && inst_valid_q && bus.inst_ready;
    end

    assign bus.mem_enable  = issue_s;
    assign bus.mem_address = issue_s ? ADDR_W'(pc_to_word(pc_q)) : '0;

    fetch_skid_buf #(.DATA_W(DATA_W)) u_skid (
        .clk      (clk),
        .reset    (reset),
        .load_i   (skid_load_s),
        .unload_i (skid_unload_s),
        .flush_i  (bus.branch_valid),
        .data_i   (bus.mem_data),
        .pc_i     (pend_pc_q),
        .full_o   (skid_full_s),
        .data_o   (skid_data_s),
        .pc_o     (skid_pc_s)
    );

    // PC, in-flight tracking, output register and RUN/STALL state machine.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_RUN;
            pc_q         <= RESET_PC & ~32'd3;
            pend_q       <= 1'b0;
            pend_pc_q    <= 32'd0;
            inst_valid_q <= 1'b0;
            inst_data_q  <= '0;
            inst_pc_q    <= 32'd0;
        end else if (bus.branch_valid) begin
            // Redirect: drop the in-flight response and any buffered/presented instruction.
            state_q      <= S_RUN;
            pc_q         <= bus.branch_target & ~32'd3;
            pend_q       <= 1'b0;
            inst_valid_q <= 1'b0;
        end else begin
            pend_q <= issue_s;
            if (issue_s) begin
                pc_q      <= pc_d;
                pend_pc_q <= pc_q;
            end
            case (state_q)
                S_RUN: begin
                    if (pend_q && out_free_s) begin
                        inst_valid_q <= 1'b1;
                        inst_data_q  <= bus.mem_data;
                        inst_pc_q    <= pend_pc_q;
                    end else if (pend_q) begin
                        // Response parked in the skid entry by u_skid this edge.
                        state_q <= S_STALL;
                    end else if (bus.inst_ready) begin
                        inst_valid_q <= 1'b0;
                    end
                end
                S_STALL: begin
                    if (bus.inst_ready && skid_full_s) begin
                        inst_valid_q <= 1'b1;
                        inst_data_q  <= skid_data_s;
                        inst_pc_q    <= skid_pc_s;
                        state_q      <= S_RUN;
                    end
                end
                default: begin
                    state_q <= S_RUN;
                end
            endcase
        end
    end

    assign bus.inst_valid = inst_valid_q;
    assign bus.inst_data  = inst_data_q;
    assign bus.inst_pc    = inst_pc_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;

    // Saturating counters of accepted instructions and back-pressured cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_q <= 32'd0;
            perf_stall_q   <= 32'd0;
        end else begin
            if (inst_valid_q && bus.inst_ready && (perf_fetched_q != 32'hFFFF_FFFF)) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (inst_valid_q && !bus.inst_ready && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a directed per-cycle stimulus table pushes
// the instructions decode is expected to accept; a monitor pops on every
// valid&&ready transfer and also checks cycle-exact latency points.
module tb_fetch_unit;
    import fetch_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   failures;
    exp_t exp_q[$];
    logic [31:0] mem_q;

    fetch_if #(.ADDR_W(18), .DATA_W(32)) bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(18), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = -4;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: 1-cycle registered read, mem[i] = E000_0000 + i.
    always @(posedge clk) begin
        if (bus.mem_enable) mem_q <= 32'hE000_0000 + {14'd0, bus.mem_address};
    end
    assign bus.mem_data = mem_q;

    function automatic exp_t mk(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.data = 32'hE000_0000 + (pc >> 2);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle stimulus plus expected-accept pushes.
    task automatic drive(input int c);
        reset             = (c < 0) || (c == 21);
        bus.inst_ready    = (c >= 0) && !(c inside {3, 4, 5, 9, 10, 21, 26, 27, 28, 33});
        bus.branch_valid  = (c == 10) || (c == 16);
        bus.branch_target = (c == 16) ? 32'h0000_0043 : 32'h0000_0040;
        if (c == 0) begin
            exp_q.push_back(mk(32'h0)); exp_q.push_back(mk(32'h4)); exp_q.push_back(mk(32'h8));
        end
        if (c == 10) begin
            exp_q.push_back(mk(32'h40)); exp_q.push_back(mk(32'h44));
            exp_q.push_back(mk(32'h48)); exp_q.push_back(mk(32'h4C));
        end
        if (c == 16) begin
            exp_q.push_back(mk(32'h40)); exp_q.push_back(mk(32'h44));
        end
        if (c == 21) begin
            for (int i = 0; i < 5; i++) exp_q.push_back(mk(32'(i * 4)));
        end
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        reset             = 1'b1;
        bus.inst_ready    = 1'b0;
        bus.branch_valid  = 1'b0;
        bus.branch_target = 32'd0;
        for (int c = -3; c <= 33; c++) begin
            @(posedge clk);
            #1;
            drive(c);
        end
        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Monitor: scoreboard pops, hold-stability and cycle-exact timing points.
    initial begin
        exp_t        e;
        logic        hold_v;
        logic [31:0] hold_pc;
        logic [31:0] hold_data;
        hold_v = 1'b0;
        hold_pc = 32'd0;
        hold_data = 32'd0;
        forever begin
            @(negedge clk);
            if (hold_v) begin
                chk("hold_valid", 32'(bus.inst_valid), 32'd1);
                chk("hold_pc", bus.inst_pc, hold_pc);
                chk("hold_data", bus.inst_data, hold_data);
            end
            hold_v    = bus.inst_valid && !bus.inst_ready && !reset && !bus.branch_valid;
            hold_pc   = bus.inst_pc;
            hold_data = bus.inst_data;
            if (bus.inst_valid && bus.inst_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_accept_pc", bus.inst_pc, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("accept_pc", bus.inst_pc, e.pc);
                    chk("accept_data", bus.inst_data, e.data);
                end
            end
            case (cyc)
                -2: begin
                    chk("rst_valid", 32'(bus.inst_valid), 32'd0);
                    chk("rst_data", bus.inst_data, 32'd0);
                    chk("rst_pc", bus.inst_pc, 32'd0);
                    chk("rst_en", 32'(bus.mem_enable), 32'd0);
                    chk("rst_addr", 32'(bus.mem_address), 32'd0);
                end
                0: begin
                    chk("first_issue_en", 32'(bus.mem_enable), 32'd1);
                    chk("first_issue_addr", 32'(bus.mem_address), 32'd0);
                end
                1: chk("lat_valid_c1", 32'(bus.inst_valid), 32'd0);
                2: begin
                    chk("lat_valid_c2", 32'(bus.inst_valid), 32'd1);
                    chk("lat_pc_c2", bus.inst_pc, 32'd0);
                end
                3, 4, 5: begin
                    chk("stall_no_issue", 32'(bus.mem_enable), 32'd0);
                    chk("stall_pc", bus.inst_pc, 32'h4);
                end
                6: chk("skid_unload_no_issue", 32'(bus.mem_enable), 32'd0);
                7: begin
                    chk("resume_en", 32'(bus.mem_enable), 32'd1);
                    chk("resume_addr", 32'(bus.mem_address), 32'd3);
                end
                10, 21: chk("br_rst_no_issue", 32'(bus.mem_enable), 32'd0);
                11, 17: begin
                    chk("br_valid_t1", 32'(bus.inst_valid), 32'd0);
                    chk("br_issue_en", 32'(bus.mem_enable), 32'd1);
                    chk("br_issue_addr", 32'(bus.mem_address), 32'h10);
                end
                12, 18, 23: chk("valid_gap", 32'(bus.inst_valid), 32'd0);
                13, 19: begin
                    chk("br_valid_t3", 32'(bus.inst_valid), 32'd1);
                    chk("br_pc_t3", bus.inst_pc, 32'h40);
                    chk("br_data_t3", bus.inst_data, 32'hE000_0010);
                end
                22: begin
                    chk("post_rst_valid", 32'(bus.inst_valid), 32'd0);
                    chk("post_rst_en", 32'(bus.mem_enable), 32'd1);
                    chk("post_rst_addr", 32'(bus.mem_address), 32'd0);
                end
                24: begin
                    chk("post_rst_first_valid", 32'(bus.inst_valid), 32'd1);
                    chk("post_rst_first_pc", bus.inst_pc, 32'd0);
                end
                26, 27, 28: chk("stall2_no_issue", 32'(bus.mem_enable), 32'd0);
                33: begin
                    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
`ifdef FETCH_PERF_EN
                    chk("perf_fetched", perf_fetched, 32'd5);
                    chk("perf_stall", perf_stall, 32'd3);
`endif
                end
                default: begin
                end
            endcase
        end
    end
endmodule
